// File: rtl/fasta_base_feeder.sv
// FASTA byte-stream front end: strips headers/whitespace, packs ACGT into 2-bit
// codes, buffers one sequence and bursts it contiguously into the scoring array.
module fasta_base_feeder #(
  parameter int unsigned MAX_LEN    = 256,
  parameter int unsigned LEN_WIDTH  = 9,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           char_in,
  input  logic                 char_vld,
  output logic                 char_rdy,
  input  logic                 eof,
  output logic [1:0]           data_out,
  output logic                 en_out,
  output logic                 seq_start,
  output logic                 seq_done,
  output logic [ID_WIDTH-1:0]  seq_id,
  output logic [LEN_WIDTH-1:0] seq_len,
  output logic                 bad_char,
  output logic                 len_ovf
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES + 2);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_LEN);

  localparam logic [7:0] CH_GT  = 8'h3E;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_TAB = 8'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LOAD,
    ST_DRAIN,
    ST_GAP
  } state_e;

  function automatic logic is_base(input logic [7:0] c);
    case (c)
      8'h41, 8'h61, 8'h43, 8'h63, 8'h47, 8'h67, 8'h54, 8'h74: is_base = 1'b1;
      default:                                                is_base = 1'b0;
    endcase
  endfunction

  function automatic logic is_ws(input logic [7:0] c);
    is_ws = (c == CH_LF) || (c == CH_CR) || (c == CH_SP) || (c == CH_TAB);
  endfunction

  function automatic logic [1:0] enc_base(input logic [7:0] c);
    case (c)
      8'h41, 8'h61: enc_base = 2'b10;
      8'h43, 8'h63: enc_base = 2'b01;
      8'h47, 8'h67: enc_base = 2'b11;
      default:      enc_base = 2'b00;
    endcase
  endfunction

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] seq_len_q, seq_len_d;
  logic [LEN_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [ID_WIDTH-1:0]  seq_id_q, seq_id_d;
  logic                 term_gt_q, term_gt_d;
  logic                 bad_char_q, bad_char_d;
  logic                 len_ovf_q, len_ovf_d;
  logic                 en_out_q, en_out_d;
  logic [1:0]           data_out_q, data_out_d;
  logic                 seq_start_q, seq_start_d;
  logic                 seq_done_q, seq_done_d;
  logic                 char_rdy_q, char_rdy_d;

  logic                 accept_c;
  logic                 term_c;
  logic                 gt_c;
  logic                 wr_en;
  logic [AW-1:0]        wr_idx;
  logic [1:0]           wr_data;

  // Sequence store; contents are don't-care until written, so no reset.
  logic [1:0] base_mem_q [MAX_LEN];

  assign accept_c = char_vld && char_rdy_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    seq_len_d   = seq_len_q;
    rd_cnt_d    = rd_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    seq_id_d    = seq_id_q;
    term_gt_d   = term_gt_q;
    bad_char_d  = bad_char_q;
    len_ovf_d   = len_ovf_q;
    en_out_d    = 1'b0;
    data_out_d  = 2'b00;
    seq_start_d = 1'b0;
    seq_done_d  = 1'b0;
    term_c      = 1'b0;
    gt_c        = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = AW'(seq_len_q);
    wr_data     = enc_base(char_in);

    case (state_q)
      ST_IDLE: begin
        if (accept_c && (char_in == CH_GT)) state_d = ST_HEADER;
        if (eof)                            state_d = ST_IDLE;
      end
      ST_HEADER: begin
        if (accept_c && (char_in == CH_LF)) begin
          state_d   = ST_LOAD;
          seq_len_d = '0;
        end
        if (eof) state_d = ST_IDLE;
      end
      ST_LOAD: begin
        term_c = eof;
        if (accept_c) begin
          if (is_base(char_in)) begin
            if (seq_len_q < LEN_MAX) begin
              wr_en     = 1'b1;
              seq_len_d = seq_len_q + LEN_WIDTH'(1);
            end else begin
              len_ovf_d = 1'b1;
            end
          end else if (char_in == CH_GT) begin
            term_c = 1'b1;
            gt_c   = !eof;
          end else if (!is_ws(char_in)) begin
            bad_char_d = 1'b1;
          end
        end
        // The byte is folded in first; an empty sequence never bursts.
        if (term_c) begin
          if (seq_len_d != '0) begin
            state_d   = ST_DRAIN;
            rd_cnt_d  = '0;
            term_gt_d = gt_c;
          end else begin
            state_d = gt_c ? ST_HEADER : ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        en_out_d    = 1'b1;
        data_out_d  = base_mem_q[AW'(rd_cnt_q)];
        seq_start_d = (rd_cnt_q == '0);
        rd_cnt_d    = rd_cnt_q + LEN_WIDTH'(1);
        if (rd_cnt_q == (seq_len_q - LEN_WIDTH'(1))) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        seq_done_d = (gap_cnt_q == '0);
        gap_cnt_d  = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GW'(GAP_CYCLES)) begin
          state_d  = term_gt_q ? ST_HEADER : ST_IDLE;
          seq_id_d = seq_id_q + ID_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    char_rdy_d = (state_d == ST_IDLE) || (state_d == ST_HEADER) || (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      seq_len_q   <= '0;
      rd_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      seq_id_q    <= '0;
      term_gt_q   <= 1'b0;
      bad_char_q  <= 1'b0;
      len_ovf_q   <= 1'b0;
      en_out_q    <= 1'b0;
      data_out_q  <= 2'b00;
      seq_start_q <= 1'b0;
      seq_done_q  <= 1'b0;
      char_rdy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_len_q   <= seq_len_d;
      rd_cnt_q    <= rd_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      seq_id_q    <= seq_id_d;
      term_gt_q   <= term_gt_d;
      bad_char_q  <= bad_char_d;
      len_ovf_q   <= len_ovf_d;
      en_out_q    <= en_out_d;
      data_out_q  <= data_out_d;
      seq_start_q <= seq_start_d;
      seq_done_q  <= seq_done_d;
      char_rdy_q  <= char_rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) base_mem_q[wr_idx] <= wr_data;
  end

  assign char_rdy  = char_rdy_q;
  assign data_out  = data_out_q;
  assign en_out    = en_out_q;
  assign seq_start = seq_start_q;
  assign seq_done  = seq_done_q;
  assign seq_id    = seq_id_q;
  assign seq_len   = seq_len_q;
  assign bad_char  = bad_char_q;
  assign len_ovf   = len_ovf_q;

endmodule

// File: tb/tb_fasta_base_feeder.sv
// Directed bench for fasta_base_feeder: FASTA streams in, captured bursts
// compared against hand-derived 2-bit codes (A=2 C=1 G=3 T=0).
module tb_fasta_base_feeder;

  localparam int unsigned MAX_LEN = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_vld = 1'b0;
  logic       char_rdy;
  logic       eof = 1'b0;
  logic [1:0] data_out;
  logic       en_out;
  logic       seq_start;
  logic       seq_done;
  logic [7:0] seq_id;
  logic [8:0] seq_len;
  logic       bad_char;
  logic       len_ovf;

  int n_cmp = 0;
  int n_err = 0;

  fasta_base_feeder #(
    .MAX_LEN(MAX_LEN), .LEN_WIDTH(9), .ID_WIDTH(8), .GAP_CYCLES(1)
  ) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_vld(char_vld),
    .char_rdy(char_rdy), .eof(eof), .data_out(data_out), .en_out(en_out),
    .seq_start(seq_start), .seq_done(seq_done), .seq_id(seq_id),
    .seq_len(seq_len), .bad_char(bad_char), .len_ovf(len_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Burst capture: one record per contiguous en_out run.
  logic [1:0] bases[$];
  int lens[$];
  int ids[$];
  int starts[$];
  int dones[$];
  int cur_len, cur_id, start_ok;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_en = 1'b0;
    end else begin
      if (en_out) begin
        if (!prev_en) begin
          cur_len  = 0;
          cur_id   = int'(seq_id);
          start_ok = seq_start ? 1 : 0;
        end else if (seq_start) begin
          start_ok = 0;
        end
        bases.push_back(data_out);
        cur_len++;
      end else if (prev_en) begin
        lens.push_back(cur_len);
        ids.push_back(cur_id);
        starts.push_back(start_ok);
        dones.push_back(seq_done ? 1 : 0);
      end
      prev_en = en_out;
    end
  end

  task automatic clear_cap();
    bases.delete(); lens.delete(); ids.delete(); starts.delete(); dones.delete();
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!char_rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!char_rdy) check({tag, "_rdy_timeout"}, 32'(char_rdy), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_idle);
    int idle;
    idle = (max_idle > 0) ? int'($urandom_range(0, max_idle)) : 0;
    repeat (idle) @(negedge clk);
    @(negedge clk);
    wait_rdy("send");
    char_in  = b;
    char_vld = 1'b1;
    @(posedge clk);
    #1 char_vld = 1'b0;
  endtask

  task automatic send_str(input string s, input int max_idle);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], max_idle);
  endtask

  task automatic send_eof();
    @(negedge clk);
    wait_rdy("eof");
    eof = 1'b1;
    @(posedge clk);
    #1 eof = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    wait_rdy("settle");
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_cap();
  endtask

  // Compare captured bursts to a digit string of expected codes.
  task automatic check_cap(input string tag, input string exp_codes, input int exp_bursts);
    int nb;
    logic [7:0] ch;
    check({tag, "_bursts"}, 32'(lens.size()), 32'(exp_bursts));
    check({tag, "_bases"}, 32'(bases.size()), 32'(exp_codes.len()));
    nb = (bases.size() < exp_codes.len()) ? bases.size() : exp_codes.len();
    for (int i = 0; i < nb; i++) begin
      ch = exp_codes[i];
      check($sformatf("%s_data%0d", tag, i), 32'(bases[i]), 32'(ch - 8'd48));
    end
    for (int i = 0; i < lens.size(); i++) begin
      check($sformatf("%s_start%0d", tag, i), 32'(starts[i]), 32'd1);
      check($sformatf("%s_done%0d", tag, i), 32'(dones[i]), 32'd1);
    end
  endtask

  initial begin
    logic [1:0] pat [4];
    string acgt;
    int bad;
    pat  = '{2'b10, 2'b01, 2'b11, 2'b00};
    acgt = "ACGT";

    // reset values while rst is held low
    #2;
    check("rst_en_out", 32'(en_out), 32'd0);
    check("rst_char_rdy", 32'(char_rdy), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_seq_id", 32'(seq_id), 32'd0);
    check("rst_seq_len", 32'(seq_len), 32'd0);
    check("rst_flags", 32'({seq_start, seq_done, bad_char, len_ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", 32'(char_rdy), 32'd1);
    clear_cap();

    // two records
    send_str(">a\nACGT\n>b\nTTG\n", 0);
    send_eof();
    settle();
    check_cap("two", "2130003", 2);
    if (lens.size() == 2) begin
      check("two_len0", 32'(lens[0]), 32'd4);
      check("two_len1", 32'(lens[1]), 32'd3);
      check("two_id0", 32'(ids[0]), 32'd0);
      check("two_id1", 32'(ids[1]), 32'd1);
    end
    check("two_seq_len", 32'(seq_len), 32'd3);
    check("two_seq_id", 32'(seq_id), 32'd2);
    check("two_flags", 32'({bad_char, len_ovf}), 32'd0);

    // multi-line lower case with input gaps
    do_reset();
    send_str(">x\nac\ngt\n", 3);
    send_eof();
    settle();
    check_cap("ml", "2130", 1);
    check("ml_seq_len", 32'(seq_len), 32'd4);

    // bad character dropped, flag sticky
    do_reset();
    send_str(">x\nANC\n", 0);
    send_eof();
    settle();
    check_cap("bad", "21", 1);
    check("bad_flag", 32'(bad_char), 32'd1);
    clear_cap();
    send_str(">y\nG\n", 0);
    send_eof();
    settle();
    check_cap("bad2", "3", 1);
    if (ids.size() == 1) check("bad2_id", 32'(ids[0]), 32'd1);
    check("bad_sticky", 32'(bad_char), 32'd1);

    // overflow: MAX_LEN+3 bases
    do_reset();
    send_str(">m\n", 0);
    for (int i = 0; i < MAX_LEN + 3; i++) send_byte(acgt[i % 4], 0);
    send_eof();
    settle();
    check("ovf_bursts", 32'(lens.size()), 32'd1);
    if (lens.size() == 1) check("ovf_burst_len", 32'(lens[0]), 32'(MAX_LEN));
    bad = 0;
    for (int i = 0; i < bases.size() && i < MAX_LEN; i++)
      if (bases[i] !== pat[i % 4]) bad++;
    check("ovf_data_errs", 32'(bad), 32'd0);
    check("ovf_flag", 32'(len_ovf), 32'd1);
    check("ovf_seq_len", 32'(seq_len), 32'(MAX_LEN));

    // empty record skipped, plus exact burst timing for L=1
    do_reset();
    send_str(">e\n>f\nG\n", 0);
    send_eof();
    @(negedge clk);
    check("t_n0_en", 32'(en_out), 32'd0);
    check("t_n0_rdy", 32'(char_rdy), 32'd0);
    @(negedge clk);
    check("t_n1_en", 32'(en_out), 32'd1);
    check("t_n1_data", 32'(data_out), 32'd3);
    check("t_n1_start", 32'(seq_start), 32'd1);
    check("t_n1_id", 32'(seq_id), 32'd0);
    @(negedge clk);
    check("t_n2_en", 32'(en_out), 32'd0);
    check("t_n2_done", 32'(seq_done), 32'd1);
    check("t_n2_rdy", 32'(char_rdy), 32'd0);
    @(negedge clk);
    check("t_n3_rdy", 32'(char_rdy), 32'd1);
    check("t_n3_done", 32'(seq_done), 32'd0);
    check("t_n3_id", 32'(seq_id), 32'd1);
    settle();
    check_cap("empty", "3", 1);
    if (ids.size() == 1) check("empty_id", 32'(ids[0]), 32'd0);

    // reset mid-burst
    do_reset();
    send_str(">q\nACGT\n", 0);
    send_eof();
    begin
      int n = 0;
      @(negedge clk);
      while (!en_out && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("mid_burst_seen", 32'(en_out), 32'd1);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_en_out", 32'(en_out), 32'd0);
    check("mid_data_out", 32'(data_out), 32'd0);
    check("mid_rdy", 32'(char_rdy), 32'd0);
    check("mid_seq_len", 32'(seq_len), 32'd0);
    check("mid_seq_id", 32'(seq_id), 32'd0);
    check("mid_flags", 32'({seq_start, seq_done, bad_char, len_ovf}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_cap();
    send_str(">q\nC\n", 0);
    send_eof();
    settle();
    check_cap("post_rst", "1", 1);
    if (ids.size() == 1) check("post_rst_id", 32'(ids[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fasta_base_feeder.md
# fasta_base_feeder

Upstream feeder for `ScoringModule`. Accepts a byte stream of FASTA text (header lines beginning `>`, then sequence lines), strips headers and line breaks, and encodes each nucleotide to 2 bits. Each complete target sequence is buffered, then burst into the scoring array. The burst holds `en_out` high for exactly one contiguous run per sequence, followed by a guaranteed idle gap, so `ScoringModule` produces one `vld`/`result` per sequence.

## Interface
- `MAX_LEN`, 256: base buffer depth, 2 bits per entry; longest sequence accepted.
- `LEN_WIDTH`, 9: width of `seq_len`; must hold `MAX_LEN`.
- `ID_WIDTH`, 8: width of `seq_id`.
- `GAP_CYCLES`, 1: idle cycles with `en_out` low after each burst; minimum 1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `char_in`  in  8  ASCII byte.
- `char_vld`  in  1  `char_in` valid.
- `char_rdy`  out  1  byte accepted on an edge where `char_vld && char_rdy`.
- `eof`  in  1  end-of-stream pulse; may coincide with an accepted byte.
- `data_out`  out  2  encoded base; drives `ScoringModule` `data_in`.
- `en_out`  out  1  base valid; drives `en_in`.
- `seq_start`  out  1  pulse, coincident with the first base of a burst.
- `seq_done`  out  1  pulse, first cycle after the last base.
- `seq_id`  out  ID_WIDTH  index of the current or last burst; 0-based, wraps.
- `seq_len`  out  LEN_WIDTH  bases in the current or last sequence.
- `bad_char`  out  1  sticky; a non-ACGT, non-whitespace byte was seen in sequence text.
- `len_ovf`  out  1  sticky; a sequence exceeded `MAX_LEN`.

## Operation
- Encoding is case-insensitive: A=2'b10, G=2'b11, T=2'b00, C=2'b01.
- Whitespace is LF, CR, space, or tab.
- FSM states: IDLE, HEADER, LOAD, DRAIN, GAP.
- IDLE: consumes bytes. `>` goes to HEADER; all other bytes are discarded.
- HEADER: consumes bytes until LF, then goes to LOAD with `seq_len` cleared.
- LOAD: each accepted ACGT byte writes `buf[seq_len]` and increments `seq_len`.
  - Whitespace is ignored, so multi-line sequences are supported.
  - Any other byte except `>` is dropped and sets `bad_char`.
- LOAD termination: an accepted `>` or `eof` ends the sequence.
  - If `seq_len` > 0, go to DRAIN.
  - If `seq_len` = 0, go directly to HEADER (`>`) or IDLE (`eof`). No burst occurs and `seq_id` does not advance.
- Overflow: bases beyond `MAX_LEN` are dropped. `seq_len` saturates at `MAX_LEN` and `len_ovf` is set.
- DRAIN: reads `buf[0..seq_len-1]` at one base per cycle. `char_rdy` = 0.
- GAP: holds `en_out` low for `GAP_CYCLES` cycles. `char_rdy` = 0.
  - Then goes to HEADER if the burst was terminated by `>`, otherwise to IDLE.
  - `seq_id` increments on GAP exit.
- `eof` in IDLE or HEADER: go to IDLE; a partial header is discarded.
- `eof` with an accepted byte in the same cycle: the byte is processed first, then `eof` applies.
- `char_rdy` = 1 in IDLE, HEADER, and LOAD; 0 in DRAIN and GAP.

## Timing
- Reset (asynchronous, while `rst` low):
  - state IDLE;
  - `en_out`, `seq_start`, `seq_done`, `char_rdy` = 0;
  - `data_out` = 2'b00;
  - `seq_id`, `seq_len` = 0;
  - `bad_char`, `len_ovf` = 0.
- `char_rdy` rises on the first edge after `rst` deasserts.
- Buffer contents are not reset.
- Burst timing, for a terminator accepted at edge N with length L:
  - `en_out` and `seq_start` rise at edge N+1;
  - `en_out` stays high through edge N+L, with `data_out` = `buf[k]` during cycle N+1+k;
  - `seq_done` is high for the cycle following edge N+L+1;
  - `char_rdy` reasserts at edge N+L+GAP_CYCLES+1.
- Stall-free guarantee: `en_out` never drops inside a burst, regardless of `char_vld` gaps during LOAD.
- Outputs are registered. `seq_len` is stable from DRAIN entry through GAP exit.
- Reset asserted mid-LOAD or mid-DRAIN aborts immediately: `en_out` drops asynchronously and the partial sequence is lost.

## Test plan
- Two-record stream `>a\nACGT\n>b\nTTG\n` then `eof`:
  - burst 1 is 4 cycles, `data_out` 10,01,11,00, `seq_id` 0;
  - burst 2 is 3 cycles, `data_out` 00,00,11, `seq_id` 1;
  - each burst is followed by ≥1 low cycle and a `seq_done` pulse.
- Multi-line, lower-case, random `char_vld` gaps (`>x\nac\ngt\n`, `eof`) -> one contiguous 4-cycle burst 10,01,11,00 with `seq_len` = 4.
- `>x\nANC\n`, `eof` -> 2-cycle burst 10,01; `bad_char` = 1 sticky.
- `MAX_LEN`+3 bases -> burst of exactly `MAX_LEN` cycles; `len_ovf` = 1; `seq_len` = `MAX_LEN`.
- `>e\n>f\nG\n`, `eof` -> no burst for `e`; a single 1-cycle burst 11 with `seq_id` 0.
- `rst` pulsed low at burst cycle 2 -> `en_out` is 0 immediately and all outputs return to reset values; a fresh `>q\nC\n`, `eof` then yields one burst 01 with `seq_id` 0.
